sdcram_dumper: RTL and testbench
================================

Name: sdcram_dumper

Overview:
- Streams a contiguous DRAM region into the SD card through the sdcram user interface. It is the write-direction counterpart of the boot-time SD program loader.
- Software or a debug trigger provides a DRAM base address, an SD byte address and a word count, then pulses start.
- The block reads DRAM one word at a time, buffers words in a small FIFO and issues full-word sdcram writes.
- It sits beside the loader on the sdcram address/ren/wen mux; the mux selects this block while o_busy=1.

Parameters:
- FIFO_DEPTH, 4, word buffer entries between the DRAM read side and the sdcram write side; power of two, minimum 2.
- CNT_W, 24, width of the word counter (maximum transfer is 2^CNT_W-1 words).

Ports:
- i_clk  in  1  system clock; single clock domain.
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  one-cycle start pulse; sampled only when o_busy=0.
- i_abort  in  1  level; stop issuing new DRAM reads.
- i_dram_base  in  32  DRAM byte address of the first word; bits[1:0] are ignored (treated as 0).
- i_sd_base  in  41  sdcram byte address of the first word; bits[1:0] are ignored.
- i_word_count  in  CNT_W  number of 32-bit words to transfer.
- o_dram_addr  out  32  DRAM read address.
- o_dram_ren  out  1  one-cycle DRAM read request.
- i_dram_busy  in  1  DRAM busy; a request may only be issued while this is 0.
- i_dram_valid  in  1  one-cycle pulse; i_dram_rdata is valid in that cycle.
- i_dram_rdata  in  32  DRAM read data.
- o_sdcram_addr  out  41  sdcram byte address.
- o_sdcram_wen  out  4  byte write enables; either 4'hF for one cycle or 4'h0.
- o_sdcram_wdata  out  32  sdcram write data.
- i_sdcram_busy  in  1  sdcram busy.
- o_busy  out  1  transfer in progress.
- o_done  out  1  one-cycle completion pulse.
- o_aborted  out  1  set with o_done when the transfer ended by abort; held until the next start.
- o_words_written  out  CNT_W  count of sdcram writes accepted in the current or last transfer.

Behaviour:
- Reset (i_rst=1 at a clock edge):
  - All outputs go to 0 and both FSMs return to IDLE.
  - FIFO and counters are cleared.
  - A transfer in flight is dropped; a DRAM response arriving after reset is ignored.
- Start:
  - Accepted when i_start=1 and o_busy=0. i_start while o_busy=1 is ignored.
  - On acceptance the block latches the bases (low 2 bits forced to 0) and the count, clears o_words_written and o_aborted, and sets o_busy next cycle.
  - If i_word_count=0, o_busy stays 0 and o_done pulses in the cycle after start, with no bus activity.
- Read FSM (R_IDLE, R_REQ, R_WAIT):
  - R_IDLE -> R_REQ when busy, reads_issued<count, !abort_latched, and fifo_count+outstanding<FIFO_DEPTH.
  - R_REQ asserts o_dram_ren for exactly 1 cycle, only while i_dram_busy=0. o_dram_addr = base + 4*reads_issued. outstanding becomes 1 and the FSM moves to R_WAIT.
  - R_WAIT: on i_dram_valid the word is pushed into the FIFO, outstanding becomes 0 and the FSM returns to R_IDLE.
  - At most one DRAM read is outstanding. The FIFO never overflows; a push when full is a design error and is asserted in simulation.
- Write FSM (W_IDLE, W_REQ, W_GAP, W_WAIT):
  - W_IDLE -> W_REQ when the FIFO is non-empty.
  - W_REQ: when i_sdcram_busy=0, assert o_sdcram_wen=4'hF for 1 cycle. o_sdcram_addr = sd_base + 4*o_words_written and o_sdcram_wdata = FIFO head. Then pop the FIFO and go to W_GAP.
  - W_GAP: 1 cycle, with busy ignored, to cover the sdcram busy rise latency. Then go to W_WAIT.
  - W_WAIT: when i_sdcram_busy=0, increment o_words_written and go to W_IDLE.
  - o_sdcram_addr and o_sdcram_wdata hold their values from W_REQ until the next write; they are 0 after reset.
- Simultaneous events: a FIFO push and pop in the same cycle leave fifo_count unchanged.
- Address arithmetic:
  - The DRAM address wraps modulo 2^32.
  - The SD address wraps modulo 2^41.
  - No error flag is raised on wrap.
- Abort:
  - i_abort=1 while busy sets abort_latched. No new DRAM reads are issued after that.
  - Words already requested or buffered are still written, so no read data is lost.
  - Completion then follows the abort rule below.
- Completion:
  - Normal completion occurs when o_words_written==count, or when abort_latched=1 with outstanding=0, the FIFO empty and the write FSM in W_IDLE.
  - On completion: o_busy goes to 0, o_done pulses 1 cycle, and o_aborted=abort_latched.
  - i_abort while idle has no effect.
- Latency: the first o_sdcram_wen occurs no earlier than 2 cycles after the first i_dram_valid.

Test Plan:
- Reset, then 3 cycles idle -> all outputs 0; o_dram_ren and o_sdcram_wen are never asserted.
- start, dram_base=0x8000_0003, sd_base=0x100, count=3; DRAM valid 2 cycles after each ren; sdcram busy 5 cycles per write:
  - -> DRAM reads at 0x8000_0000, _0004 and _0008.
  - -> SD writes at 0x100, 0x104 and 0x108 carrying the read data in order.
  - -> o_done pulses once, o_words_written=3 and o_aborted=0.
- count=10 with i_sdcram_busy held high for 40 cycles -> at most FIFO_DEPTH=4 DRAM reads are issued before the first write; after busy releases, all 10 words are written in order.
- count=8; assert i_abort after the 2nd i_dram_valid, with one read outstanding -> that read completes; o_words_written=3; o_done and o_aborted are both 1.
- count=0 -> o_done pulses the cycle after start; no ren or wen; o_busy stays 0.
- i_rst asserted mid-transfer between ren and valid -> all outputs 0 next cycle; the late i_dram_valid causes no FIFO push; a new start with count=1 completes normally.

Source files
------------

// File: rtl/sdcram_dumper.sv
// Copies a contiguous DRAM region to the SD card through the sdcram user port.
// A read FSM fills a small word FIFO; a write FSM drains it with full-word writes.
module sdcram_dumper #(
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 24
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic             i_abort,
   input  logic [31:0]      i_dram_base,
   input  logic [40:0]      i_sd_base,
   input  logic [CNT_W-1:0] i_word_count,
   output logic [31:0]      o_dram_addr,
   output logic             o_dram_ren,
   input  logic             i_dram_busy,
   input  logic             i_dram_valid,
   input  logic [31:0]      i_dram_rdata,
   output logic [40:0]      o_sdcram_addr,
   output logic [3:0]       o_sdcram_wen,
   output logic [31:0]      o_sdcram_wdata,
   input  logic             i_sdcram_busy,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_aborted,
   output logic [CNT_W-1:0] o_words_written
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {R_IDLE, R_REQ, R_WAIT} rstate_t;
   typedef enum logic [1:0] {W_IDLE, W_REQ, W_GAP, W_WAIT} wstate_t;

   rstate_t          rstate;
   wstate_t          wstate;
   logic [31:0]      dram_base;
   logic [40:0]      sd_base;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] reads_issued;
   logic             outstanding;
   logic             abort_latched;
   logic [31:0]      fifo_mem [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      fifo_count;

   logic push, pop, can_read, finish;

   // Only a read that is actually outstanding may push, so a response that
   // lands after reset or after the FSM left R_WAIT is dropped.
   assign push = (rstate == R_WAIT) && i_dram_valid;
   assign pop  = (wstate == W_REQ) && !i_sdcram_busy;

   assign can_read = o_busy && (reads_issued < count) && !abort_latched && !i_abort &&
                     ((fifo_count + {{AW{1'b0}}, outstanding}) < FULL);

   assign finish = o_busy &&
                   ((o_words_written == count) ||
                    (abort_latched && !outstanding && (fifo_count == '0) &&
                     (wstate == W_IDLE) && (rstate == R_IDLE)));

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rstate          <= R_IDLE;
         wstate          <= W_IDLE;
         dram_base       <= '0;
         sd_base         <= '0;
         count           <= '0;
         reads_issued    <= '0;
         outstanding     <= 1'b0;
         abort_latched   <= 1'b0;
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         fifo_count      <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
         o_dram_addr     <= '0;
         o_dram_ren      <= 1'b0;
         o_sdcram_addr   <= '0;
         o_sdcram_wen    <= 4'h0;
         o_sdcram_wdata  <= '0;
         o_busy          <= 1'b0;
         o_done          <= 1'b0;
         o_aborted       <= 1'b0;
         o_words_written <= '0;
      end else begin
         o_done       <= 1'b0;
         o_dram_ren   <= 1'b0;
         o_sdcram_wen <= 4'h0;

         if (!o_busy) begin
            if (i_start) begin
               dram_base       <= {i_dram_base[31:2], 2'b00};
               sd_base         <= {i_sd_base[40:2], 2'b00};
               count           <= i_word_count;
               reads_issued    <= '0;
               abort_latched   <= 1'b0;
               o_aborted       <= 1'b0;
               o_words_written <= '0;
               if (i_word_count == '0) o_done <= 1'b1;
               else                    o_busy <= 1'b1;
            end
         end else begin
            if (i_abort) abort_latched <= 1'b1;
            if (finish) begin
               o_busy    <= 1'b0;
               o_done    <= 1'b1;
               o_aborted <= abort_latched;
            end
         end

         case (rstate)
            R_IDLE: if (can_read) begin
               o_dram_addr <= dram_base + (32'(reads_issued) << 2);
               rstate      <= R_REQ;
            end
            R_REQ: begin
               // An abort that arrives before the request goes out cancels it.
               if (abort_latched || i_abort) begin
                  rstate <= R_IDLE;
               end else if (!i_dram_busy) begin
                  o_dram_ren   <= 1'b1;
                  outstanding  <= 1'b1;
                  reads_issued <= reads_issued + CNT_W'(1);
                  rstate       <= R_WAIT;
               end
            end
            R_WAIT: if (i_dram_valid) begin
               outstanding <= 1'b0;
               rstate      <= R_IDLE;
            end
            default: rstate <= R_IDLE;
         endcase

         case (wstate)
            W_IDLE: if (fifo_count != '0) wstate <= W_REQ;
            W_REQ: if (!i_sdcram_busy) begin
               o_sdcram_wen   <= 4'hF;
               o_sdcram_addr  <= sd_base + (41'(o_words_written) << 2);
               o_sdcram_wdata <= fifo_mem[rd_ptr];
               wstate         <= W_GAP;
            end
            // sdcram raises busy a cycle after seeing wen; don't sample it yet.
            W_GAP: wstate <= W_WAIT;
            W_WAIT: if (!i_sdcram_busy) begin
               o_words_written <= o_words_written + CNT_W'(1);
               wstate          <= W_IDLE;
            end
            default: wstate <= W_IDLE;
         endcase

         if (push) begin
            fifo_mem[wr_ptr] <= i_dram_rdata;
            wr_ptr           <= wr_ptr + AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
            2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   always @(posedge i_clk) begin
      if (!i_rst && push) assert (fifo_count != FULL);
   end

endmodule

// File: tb/tb_sdcram_dumper.sv
// Directed bench for sdcram_dumper with simple DRAM (2-cycle latency) and
// sdcram (5-cycle busy per write) responders.
module tb_sdcram_dumper;
   localparam int CNT_W = 24;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic [31:0]      dram_base = '0;
   logic [40:0]      sd_base = '0;
   logic [CNT_W-1:0] word_count = '0;
   logic [31:0]      dram_addr;
   logic             dram_ren;
   logic             dram_busy = 1'b0;
   logic             dram_valid = 1'b0;
   logic [31:0]      dram_rdata = '0;
   logic [40:0]      sdcram_addr;
   logic [3:0]       sdcram_wen;
   logic [31:0]      sdcram_wdata;
   logic             sdcram_busy;
   logic             busy, done, aborted;
   logic [CNT_W-1:0] words_written;

   sdcram_dumper #(.FIFO_DEPTH(4), .CNT_W(CNT_W)) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
      .i_dram_base(dram_base), .i_sd_base(sd_base), .i_word_count(word_count),
      .o_dram_addr(dram_addr), .o_dram_ren(dram_ren), .i_dram_busy(dram_busy),
      .i_dram_valid(dram_valid), .i_dram_rdata(dram_rdata),
      .o_sdcram_addr(sdcram_addr), .o_sdcram_wen(sdcram_wen),
      .o_sdcram_wdata(sdcram_wdata), .i_sdcram_busy(sdcram_busy),
      .o_busy(busy), .o_done(done), .o_aborted(aborted),
      .o_words_written(words_written)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] dat(input logic [31:0] a);
      return (a * 32'd3) ^ 32'h5A5A_A5A5;
   endfunction

   // Bus responders and event logs, all updated on the falling edge.
   int          dcnt = 0, sd_cnt = 0;
   logic [31:0] dpend = '0;
   logic        sd_hold = 1'b0;
   logic        bad_wen = 1'b0;
   int          rd_n = 0, wr_n = 0, done_n = 0;
   logic        done_ab = 1'b0;
   logic [31:0] rd_log [256];
   logic [40:0] wa_log [256];
   logic [31:0] wd_log [256];

   assign sdcram_busy = sd_hold | (sd_cnt != 0);

   always @(negedge clk) begin
      dram_valid = 1'b0;
      if (dcnt > 0) begin
         dcnt = dcnt - 1;
         if (dcnt == 0) begin
            dram_valid = 1'b1;
            dram_rdata = dat(dpend);
         end
      end
      if (dram_ren) begin
         dcnt  = 2;
         dpend = dram_addr;
         if (rd_n < 256) rd_log[rd_n] = dram_addr;
         rd_n = rd_n + 1;
      end
      if (sd_cnt > 0) sd_cnt = sd_cnt - 1;
      if (sdcram_wen == 4'hF) begin
         sd_cnt = 5;
         if (wr_n < 256) begin
            wa_log[wr_n] = sdcram_addr;
            wd_log[wr_n] = sdcram_wdata;
         end
         wr_n = wr_n + 1;
      end else if (sdcram_wen != 4'h0) begin
         bad_wen = 1'b1;
      end
      if (done) begin
         done_n  = done_n + 1;
         done_ab = aborted;
      end
   end

   int n_chk = 0, n_err = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic do_start(input logic [31:0] db, input logic [40:0] sb, input int cnt);
      dram_base  = db;
      sd_base    = sb;
      word_count = CNT_W'(cnt);
      start      = 1'b1;
      tick(1);
      start      = 1'b0;
   endtask

   task automatic wait_done(input int max, input string tag);
      int d0 = done_n;
      int i  = 0;
      while (done_n == d0 && i < max) begin
         tick(1);
         i++;
      end
      chk(tag, 64'(done_n != d0), 64'd1);
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, " ren"},   64'(dram_ren), 64'd0);
      chk({tag, " daddr"}, 64'(dram_addr), 64'd0);
      chk({tag, " wen"},   64'(sdcram_wen), 64'd0);
      chk({tag, " saddr"}, 64'(sdcram_addr), 64'd0);
      chk({tag, " wdata"}, 64'(sdcram_wdata), 64'd0);
      chk({tag, " busy"},  64'(busy), 64'd0);
      chk({tag, " done"},  64'(done), 64'd0);
      chk({tag, " abrt"},  64'(aborted), 64'd0);
      chk({tag, " ww"},    64'(words_written), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, expected completion");
      $fatal(1);
   end

   initial begin
      int r0, w0, d0, errs, i;

      // Reset and idle
      tick(2);
      rst = 1'b0;
      r0 = rd_n; w0 = wr_n;
      tick(3);
      chk_idle_outputs("reset");
      chk("idle reads",  64'(rd_n - r0), 64'd0);
      chk("idle writes", 64'(wr_n - w0), 64'd0);

      // Basic 3-word transfer, unaligned DRAM base
      r0 = rd_n; w0 = wr_n; d0 = done_n;
      do_start(32'h8000_0003, 41'h100, 3);
      chk("t3 busy", 64'(busy), 64'd1);
      wait_done(300, "t3 done seen");
      chk("t3 aborted", 64'(aborted), 64'd0);
      chk("t3 ww", 64'(words_written), 64'd3);
      tick(3);
      chk("t3 done once", 64'(done_n - d0), 64'd1);
      chk("t3 busy after", 64'(busy), 64'd0);
      chk("t3 nreads", 64'(rd_n - r0), 64'd3);
      chk("t3 nwrites", 64'(wr_n - w0), 64'd3);
      chk("t3 rd0", 64'(rd_log[r0]),   64'h8000_0000);
      chk("t3 rd1", 64'(rd_log[r0+1]), 64'h8000_0004);
      chk("t3 rd2", 64'(rd_log[r0+2]), 64'h8000_0008);
      chk("t3 wa0", 64'(wa_log[w0]),   64'h100);
      chk("t3 wa1", 64'(wa_log[w0+1]), 64'h104);
      chk("t3 wa2", 64'(wa_log[w0+2]), 64'h108);
      chk("t3 wd0", 64'(wd_log[w0]),   64'(dat(32'h8000_0000)));
      chk("t3 wd1", 64'(wd_log[w0+1]), 64'(dat(32'h8000_0004)));
      chk("t3 wd2", 64'(wd_log[w0+2]), 64'(dat(32'h8000_0008)));

      // Address wrap on both sides
      r0 = rd_n; w0 = wr_n;
      do_start(32'hFFFF_FFFE, 41'h1FF_FFFF_FFFD, 2);
      wait_done(300, "wrap done seen");
      chk("wrap rd0", 64'(rd_log[r0]),   64'hFFFF_FFFC);
      chk("wrap rd1", 64'(rd_log[r0+1]), 64'h0);
      chk("wrap wa0", 64'(wa_log[w0]),   64'h1FF_FFFF_FFFC);
      chk("wrap wa1", 64'(wa_log[w0+1]), 64'h0);
      chk("wrap wd1", 64'(wd_log[w0+1]), 64'(dat(32'h0)));

      // Backpressure: sdcram busy for 40 cycles, FIFO fills to depth
      sd_hold = 1'b1;
      r0 = rd_n; w0 = wr_n;
      do_start(32'h1000, 41'h2000, 10);
      tick(40);
      chk("bp reads held", 64'(rd_n - r0), 64'd4);
      chk("bp no writes", 64'(wr_n - w0), 64'd0);
      sd_hold = 1'b0;
      wait_done(600, "bp done seen");
      chk("bp nwrites", 64'(wr_n - w0), 64'd10);
      chk("bp ww", 64'(words_written), 64'd10);
      errs = 0;
      for (int k = 0; k < 10; k++) begin
         if (wa_log[w0+k] !== 41'h2000 + 41'(4*k)) errs++;
         if (wd_log[w0+k] !== dat(32'h1000 + 32'(4*k))) errs++;
      end
      chk("bp order errs", 64'(errs), 64'd0);

      // Abort with the third read outstanding
      r0 = rd_n; w0 = wr_n; d0 = done_n;
      do_start(32'h5000, 41'h600, 8);
      i = 0;
      while (rd_n - r0 < 3 && i < 200) begin
         tick(1);
         i++;
      end
      chk("ab third read", 64'(rd_n - r0), 64'd3);
      abort = 1'b1;
      wait_done(300, "ab done seen");
      chk("ab aborted w/ done", 64'(done_ab), 64'd1);
      abort = 1'b0;
      tick(5);
      chk("ab nreads", 64'(rd_n - r0), 64'd3);
      chk("ab ww", 64'(words_written), 64'd3);
      chk("ab wd2", 64'(wd_log[w0+2]), 64'(dat(32'h5008)));
      chk("ab aborted held", 64'(aborted), 64'd1);
      chk("ab done once", 64'(done_n - d0), 64'd1);

      // Zero-length transfer
      r0 = rd_n; w0 = wr_n; d0 = done_n;
      do_start(32'h7000, 41'h700, 0);
      chk("z done", 64'(done), 64'd1);
      chk("z busy", 64'(busy), 64'd0);
      chk("z aborted cleared", 64'(aborted), 64'd0);
      chk("z ww cleared", 64'(words_written), 64'd0);
      tick(5);
      chk("z done once", 64'(done_n - d0), 64'd1);
      chk("z no bus", 64'((rd_n - r0) + (wr_n - w0)), 64'd0);

      // Reset between ren and valid
      r0 = rd_n; w0 = wr_n;
      do_start(32'h3000, 41'h300, 4);
      i = 0;
      while (rd_n - r0 < 1 && i < 50) begin
         tick(1);
         i++;
      end
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk_idle_outputs("mid rst");
      tick(10);
      chk("rst no writes", 64'(wr_n - w0), 64'd0);
      chk("rst no reads", 64'(rd_n - r0), 64'd1);
      w0 = wr_n;
      do_start(32'h4000, 41'h500, 1);
      wait_done(200, "post rst done seen");
      chk("post rst ww", 64'(words_written), 64'd1);
      chk("post rst abrt", 64'(aborted), 64'd0);
      chk("post rst nw", 64'(wr_n - w0), 64'd1);
      chk("post rst wa", 64'(wa_log[w0]), 64'h500);
      chk("post rst wd", 64'(wd_log[w0]), 64'(dat(32'h4000)));

      chk("wen only 0 or F", 64'(bad_wen), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
